// File: rtl/kv_arbiter.sv
// kv_arbiter: two-requester Wishbone arbiter in front of a single keyvalue
// slave. Requester 0 is the host, requester 1 is the logic analyzer.
// Contention is settled round-robin from IDLE. A grant ends on slave ACK,
// on the owner dropping cyc, or when the wait counter expires. Expiry raises
// a one-cycle err to the owner and sets a sticky timeout flag.
//
// Handshake: a requester presents a transfer by holding cyc=1 and stb=1 with
// adr/dat/we stable. The transfer completes in the cycle the slave raises ack
// while the requester still owns the bus. That ack, and the slave read data,
// are routed combinationally back to the owner only. Deasserting cyc before
// ack abandons the transfer without any response.
module kv_arbiter #(
    parameter int ADDR_W  = 1,
    parameter int WDATA_W = 1,
    parameter int RDATA_W = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               sys_clk,
    input  logic               sys_rst,

    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    input  logic               m0_we_i,
    input  logic [ADDR_W-1:0]  m0_adr_i,
    input  logic [WDATA_W-1:0] m0_dat_i,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    output logic [RDATA_W-1:0] m0_dat_o,

    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    input  logic               m1_we_i,
    input  logic [ADDR_W-1:0]  m1_adr_i,
    input  logic [WDATA_W-1:0] m1_dat_i,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    output logic [RDATA_W-1:0] m1_dat_o,

    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic               s_we_o,
    output logic [ADDR_W-1:0]  s_adr_o,
    output logic [WDATA_W-1:0] s_dat_o,
    input  logic               s_ack_i,
    input  logic [RDATA_W-1:0] s_dat_i,

    output logic [1:0]         grant_o,
    output logic               timeout_o,
    input  logic               clr_i,

    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // The counter holds the number of completed wait cycles, so the cycle in
    // which it equals TIMEOUT-1 is the TIMEOUT-th cycle of the grant.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;      // 0 = m0 served last, 1 = m1 served last
    logic       last_grant_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic       timeout_q;
    logic       timeout_nxt;

    logic               m0_req;
    logic               m1_req;
    logic               owned;
    logic               own_sel;
    logic               own_cyc;
    logic               own_stb;
    logic               own_we;
    logic [ADDR_W-1:0]  own_adr;
    logic [WDATA_W-1:0] own_dat;
    logic               own_alive;
    logic               xfer_ack;
    logic               expire;
    logic               abort;

    assign m0_req = m0_cyc_i & m0_stb_i;
    assign m1_req = m1_cyc_i & m1_stb_i;

    assign owned   = (state == OWN0) || (state == OWN1);
    assign own_sel = (state == OWN1);

    // Select the current owner's bus signals.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        if (state == OWN0) begin
            own_cyc = m0_cyc_i;
            own_stb = m0_stb_i;
            own_we  = m0_we_i;
            own_adr = m0_adr_i;
            own_dat = m0_dat_i;
        end else if (state == OWN1) begin
            own_cyc = m1_cyc_i;
            own_stb = m1_stb_i;
            own_we  = m1_we_i;
            own_adr = m1_adr_i;
            own_dat = m1_dat_i;
        end
    end

    // A grant ends in one of three mutually exclusive ways. Ack beats expiry;
    // a dropped cyc suppresses both.
    assign own_alive = owned & own_cyc;
    assign xfer_ack  = own_alive & s_ack_i;
    assign expire    = own_alive & ~s_ack_i & (wait_cnt == WAIT_LAST);
    assign abort     = owned & ~own_cyc;

    // Slave side: follow the live owner, otherwise drive all zeros.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (own_alive) begin
            s_cyc_o = own_cyc;
            s_stb_o = own_stb;
            s_we_o  = own_we;
            s_adr_o = own_adr;
            s_dat_o = own_dat;
        end
    end

    // Requester side: only the owner sees ack, err and read data.
    always_comb begin
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        if (state == OWN0) begin
            m0_ack_o = xfer_ack;
            m0_err_o = expire;
            m0_dat_o = s_dat_i;
        end else if (state == OWN1) begin
            m1_ack_o = xfer_ack;
            m1_err_o = expire;
            m1_dat_o = s_dat_i;
        end
    end

    // Next-state logic for the FSM, the round-robin pointer, the wait counter and the timeout flag.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        wait_cnt_nxt   = wait_cnt;
        timeout_nxt    = timeout_q & ~clr_i;
        if (expire) begin
            timeout_nxt = 1'b1;
        end
        case (state)
            IDLE: begin
                wait_cnt_nxt = '0;
                if (m0_req && m1_req) begin
                    state_nxt = last_grant ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_nxt = OWN0;
                end else if (m1_req) begin
                    state_nxt = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (xfer_ack || expire || abort) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = own_sel;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            wait_cnt   <= wait_cnt_nxt;
            timeout_q  <= timeout_nxt;
        end
    end

    assign grant_o   = {state == OWN1, state == OWN0};
    assign timeout_o = timeout_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_kv_arbiter.sv
// tb_kv_arbiter: directed table of per-cycle vectors for kv_arbiter plus
// hand-written sequences for timeout, clear priority and mid-grant reset.
module tb_kv_arbiter;

    localparam logic [31:0] RDATA = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we;
    logic [0:0]  m0_adr, m0_dat;
    logic        m0_ack, m0_err;
    logic [31:0] m0_rdat;
    logic        m1_cyc, m1_stb, m1_we;
    logic [0:0]  m1_adr, m1_dat;
    logic        m1_ack, m1_err;
    logic [31:0] m1_rdat;
    logic        s_cyc, s_stb, s_we;
    logic [0:0]  s_adr, s_dat;
    logic        s_ack;
    logic [31:0] s_rdat;
    logic [1:0]  grant;
    logic        timeout;
    logic        clr;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    // clock / reset block
    always #5 clk = ~clk;

    kv_arbiter dut (
        .sys_clk  (clk),
        .sys_rst  (rst),
        .m0_cyc_i (m0_cyc),
        .m0_stb_i (m0_stb),
        .m0_we_i  (m0_we),
        .m0_adr_i (m0_adr),
        .m0_dat_i (m0_dat),
        .m0_ack_o (m0_ack),
        .m0_err_o (m0_err),
        .m0_dat_o (m0_rdat),
        .m1_cyc_i (m1_cyc),
        .m1_stb_i (m1_stb),
        .m1_we_i  (m1_we),
        .m1_adr_i (m1_adr),
        .m1_dat_i (m1_dat),
        .m1_ack_o (m1_ack),
        .m1_err_o (m1_err),
        .m1_dat_o (m1_rdat),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_adr_o  (s_adr),
        .s_dat_o  (s_dat),
        .s_ack_i  (s_ack),
        .s_dat_i  (s_rdat),
        .grant_o  (grant),
        .timeout_o(timeout),
        .clr_i    (clr),
        .state_dbg(state_dbg)
    );

    // One cycle of stimulus and the outputs expected before the next edge.
    typedef struct packed {
        logic       rst;
        logic [2:0] m0;    // cyc stb we
        logic [2:0] m1;    // cyc stb we
        logic       ack;
        logic       clr;
        logic [1:0] grant;
        logic [3:0] resp;  // m0_ack m0_err m1_ack m1_err
        logic [2:0] slv;   // s_cyc s_stb s_we
        logic       tmo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [2:0] a, input logic [2:0] b,
                       input logic k, input logic c, input logic [1:0] g,
                       input logic [3:0] rs, input logic [2:0] sl, input logic t);
        vec_t v;
        v.rst = r; v.m0 = a; v.m1 = b; v.ack = k; v.clr = c;
        v.grant = g; v.resp = rs; v.slv = sl; v.tmo = t;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // driver task: set every input for one cycle
    task automatic drive(input logic r, input logic [2:0] a, input logic [2:0] b,
                         input logic k, input logic c);
        rst = r;
        m0_cyc = a[2]; m0_stb = a[1]; m0_we = a[0];
        m1_cyc = b[2]; m1_stb = b[1]; m1_we = b[0];
        s_ack = k;
        clr = c;
    endtask

    // m1 read that runs the full wait window; optional ack / clr on the last cycle
    task automatic run_wait(input logic ack_last, input logic clr_last);
        drive(1'b0, 3'b000, 3'b110, 1'b0, 1'b0);
        #1 check("wait_idle_grant", 128'(grant), 128'(2'b00));
        @(negedge clk);
        for (int k = 1; k <= 15; k++) begin
            drive(1'b0, 3'b000, 3'b110, (k == 15) && ack_last, (k == 15) && clr_last);
            #1;
            check($sformatf("wait_c%0d", k), 128'({grant, m1_ack, m1_err}),
                  128'({2'b10, (k == 15) && ack_last, (k == 15) && !ack_last}));
            @(negedge clk);
        end
        drive(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
        #1 check("wait_end_grant", 128'(grant), 128'(2'b00));
    endtask

    initial begin
        m0_adr = 1'b1; m0_dat = 1'b1;
        m1_adr = 1'b0; m1_dat = 1'b0;
        s_rdat = RDATA;
        drive(1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        //   rst m0      m1      ack  clr  grant  resp     slv     tmo
        add(0, 3'b000, 3'b000, 1, 0, 2'b00, 4'b0000, 3'b000, 0); // reset state, idle ack ignored
        add(0, 3'b111, 3'b000, 0, 0, 2'b00, 4'b0000, 3'b000, 0); // m0 write seen
        add(0, 3'b111, 3'b000, 0, 0, 2'b01, 4'b0000, 3'b111, 0); // strobed
        add(0, 3'b111, 3'b000, 1, 0, 2'b01, 4'b1000, 3'b111, 0); // slave ack
        add(0, 3'b000, 3'b000, 0, 0, 2'b00, 4'b0000, 3'b000, 0); // idle
        add(1, 3'b000, 3'b000, 0, 0, 2'b00, 4'b0000, 3'b000, 0); // reset pointer
        add(0, 3'b110, 3'b110, 1, 0, 2'b00, 4'b0000, 3'b000, 0); // contention
        add(0, 3'b110, 3'b110, 1, 0, 2'b01, 4'b1000, 3'b110, 0); // m0 first
        add(0, 3'b110, 3'b110, 1, 0, 2'b00, 4'b0000, 3'b000, 0);
        add(0, 3'b110, 3'b110, 1, 0, 2'b10, 4'b0010, 3'b110, 0); // then m1
        add(0, 3'b110, 3'b110, 1, 0, 2'b00, 4'b0000, 3'b000, 0);
        add(0, 3'b110, 3'b110, 1, 0, 2'b01, 4'b1000, 3'b110, 0); // back to m0
        add(0, 3'b000, 3'b000, 0, 0, 2'b00, 4'b0000, 3'b000, 0);
        add(0, 3'b110, 3'b000, 0, 0, 2'b00, 4'b0000, 3'b000, 0); // m0 alone
        add(0, 3'b110, 3'b110, 0, 0, 2'b01, 4'b0000, 3'b110, 0); // wait 1
        add(0, 3'b110, 3'b110, 0, 0, 2'b01, 4'b0000, 3'b110, 0); // wait 2
        add(0, 3'b000, 3'b110, 0, 0, 2'b01, 4'b0000, 3'b000, 0); // m0 drops cyc
        add(0, 3'b000, 3'b110, 0, 0, 2'b00, 4'b0000, 3'b000, 0); // idle
        add(0, 3'b000, 3'b110, 0, 0, 2'b10, 4'b0000, 3'b110, 0); // m1 owns
        add(1, 3'b000, 3'b110, 0, 0, 2'b10, 4'b0000, 3'b110, 0); // reset mid-wait
        add(0, 3'b110, 3'b110, 0, 0, 2'b00, 4'b0000, 3'b000, 0); // cleared
        add(0, 3'b110, 3'b110, 1, 0, 2'b01, 4'b1000, 3'b110, 0); // m0 wins
        add(0, 3'b000, 3'b110, 0, 0, 2'b00, 4'b0000, 3'b000, 0);
        add(0, 3'b000, 3'b110, 1, 0, 2'b10, 4'b0010, 3'b110, 0); // m1 read data
        add(0, 3'b000, 3'b000, 0, 0, 2'b00, 4'b0000, 3'b000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            logic [31:0] e0, e1;
            logic        ea;
            drive(vecs[i].rst, vecs[i].m0, vecs[i].m1, vecs[i].ack, vecs[i].clr);
            #1;
            check($sformatf("row%0d_ctl", i),
                  128'({grant, m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we, timeout}),
                  128'({vecs[i].grant, vecs[i].resp, vecs[i].slv, vecs[i].tmo}));
            e0 = vecs[i].grant[0] ? RDATA : 32'h0;
            e1 = vecs[i].grant[1] ? RDATA : 32'h0;
            ea = (vecs[i].grant == 2'b01) && vecs[i].slv[2];
            check($sformatf("row%0d_dat", i),
                  128'({m0_rdat, m1_rdat, s_adr, s_dat}), 128'({e0, e1, ea, ea}));
            @(negedge clk);
        end

        // full timeout, then clear
        run_wait(1'b0, 1'b0);
        @(negedge clk);
        #1 check("tmo_set", 128'(timeout), 128'(1'b1));
        drive(1'b0, 3'b000, 3'b000, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
        #1 check("tmo_clr", 128'(timeout), 128'(1'b0));
        @(negedge clk);

        // ack in the expiry cycle wins
        run_wait(1'b1, 1'b0);
        @(negedge clk);
        #1 check("tmo_ack_wins", 128'(timeout), 128'(1'b0));
        @(negedge clk);

        // expiry beats a simultaneous clear
        run_wait(1'b0, 1'b1);
        @(negedge clk);
        #1 check("tmo_over_clr", 128'(timeout), 128'(1'b1));
        @(negedge clk);

        // reset during an m1 wait clears the sticky flag and the pointer
        drive(1'b0, 3'b000, 3'b110, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1 check("pre_rst_grant", 128'({grant, s_stb}), 128'({2'b10, 1'b1}));
        drive(1'b1, 3'b000, 3'b110, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'b110, 3'b110, 1'b0, 1'b0);
        #1 check("post_rst", 128'({grant, s_stb, timeout}), 128'({2'b00, 1'b0, 1'b0}));
        @(negedge clk);
        #1 check("post_rst_grant", 128'(grant), 128'(2'b01));
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
